// File: rtl/hgcal_input_quant_packer.sv
// hgcal_input_quant_packer
//   Upstream feeder for the first LUT layer of the HGCAL autoencoder.
//   Takes one raw sensor-cell charge per cycle (valid/ready). Each charge is
//   quantized to QUANT_BITS by shift-and-saturate. NUM_INPUTS quantized values
//   are packed into one flat activation word, which is handed to layer 0 over
//   a valid/ready handshake. The block is double-buffered: a pack register
//   collects the next frame while the output register waits on the consumer.
//
//   Optional build macro: HGCAL_QUANT_ROUND_EN
//     defined   -> round-to-nearest before saturation
//     undefined -> plain truncation (default)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   s_data     in   raw unsigned charge sample [IN_WIDTH]
//   s_valid    in   sample valid
//   s_last     in   last sample of a frame (qualified by s_valid)
//   s_ready    out  block can accept a sample (registered, depends on state only)
//   m_data     out  packed activations, element i at [i*QUANT_BITS +: QUANT_BITS]
//   m_valid    out  m_data valid
//   m_ready    in   consumer accepts m_data
//   frame_err  out  one-cycle pulse when a malformed frame is dropped
module hgcal_input_quant_packer #(
  parameter int IN_WIDTH   = 10,
  parameter int QUANT_BITS = 2,
  parameter int NUM_INPUTS = 48,
  parameter int SHIFT      = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH-1:0]              s_data,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [NUM_INPUTS*QUANT_BITS-1:0] m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             frame_err
);

  localparam int PACK_W = NUM_INPUTS * QUANT_BITS;
  localparam int IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IN_WIDTH:0] QMAX = (IN_WIDTH + 1)'((1 << QUANT_BITS) - 1);
`ifdef HGCAL_QUANT_ROUND_EN
  // Half an LSB of the shifted result; (1<<SHIFT)>>1 is 0 when SHIFT is 0.
  localparam logic [IN_WIDTH:0] RND = (IN_WIDTH + 1)'((1 << SHIFT) >> 1);
`endif

  typedef enum logic [1:0] {COLLECT, DROP, HOLD} state_t;

  // Clamp a shifted value to the largest code that fits QUANT_BITS.
  function automatic logic [QUANT_BITS-1:0] sat(input logic [IN_WIDTH:0] v);
    if (v > QMAX) return QMAX[QUANT_BITS-1:0];
    else          return v[QUANT_BITS-1:0];
  endfunction

  // The extra MSB keeps the rounding sum from wrapping.
  function automatic logic [QUANT_BITS-1:0] quant(input logic [IN_WIDTH-1:0] d);
    logic [IN_WIDTH:0] v;
`ifdef HGCAL_QUANT_ROUND_EN
    v = ({1'b0, d} + RND) >> SHIFT;
`else
    v = {1'b0, d} >> SHIFT;
`endif
    return sat(v);
  endfunction

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [PACK_W-1:0]   r_pack_p0, w_pack_nxt, w_pack_full;
  logic [PACK_W-1:0]   r_data_p1, w_load_data;
  logic                r_vld_p1;
  logic                r_err;
  logic                r_s_ready;
  logic                w_acc, w_out_free, w_load, w_err;
  logic [QUANT_BITS-1:0] w_q;

  assign w_q        = quant(s_data);
  assign w_acc      = s_valid && r_s_ready;
  assign w_out_free = !r_vld_p1 || m_ready;

  // Current pack with the incoming sample dropped into its slot, so a
  // completing frame can go straight to the output register.
  always_comb begin
    w_pack_full = r_pack_p0;
    w_pack_full[r_idx*QUANT_BITS +: QUANT_BITS] = w_q;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pack_nxt  = r_pack_p0;
    w_load      = 1'b0;
    w_load_data = w_pack_full;
    w_err       = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_acc) begin
          if (r_idx != LAST_IDX) begin
            if (s_last) begin
              // Short frame: discard what was collected.
              w_err      = 1'b1;
              w_idx_nxt  = '0;
              w_pack_nxt = '0;
            end else begin
              w_idx_nxt  = r_idx + 1'b1;
              w_pack_nxt = w_pack_full;
            end
          end else begin
            w_idx_nxt = '0;
            if (!s_last) begin
              // Long frame: flag now, swallow the rest up to s_last.
              w_err       = 1'b1;
              w_pack_nxt  = '0;
              w_state_nxt = DROP;
            end else if (w_out_free) begin
              w_load      = 1'b1;
              w_load_data = w_pack_full;
              w_pack_nxt  = '0;
            end else begin
              w_pack_nxt  = w_pack_full;
              w_state_nxt = HOLD;
            end
          end
        end
      end
      DROP: begin
        if (w_acc && s_last) w_state_nxt = COLLECT;
      end
      HOLD: begin
        if (r_vld_p1 && m_ready) begin
          w_load      = 1'b1;
          w_load_data = r_pack_p0;
          w_pack_nxt  = '0;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // ---- stage p0: pack register and control ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_idx     <= '0;
      r_pack_p0 <= '0;
      r_err     <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_pack_p0 <= w_pack_nxt;
      r_err     <= w_err;
      r_s_ready <= (w_state_nxt != HOLD);
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_load) begin
      r_data_p1 <= w_load_data;
      r_vld_p1  <= 1'b1;
    end else if (r_vld_p1 && m_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_data    = r_data_p1;
  assign m_valid   = r_vld_p1;
  assign frame_err = r_err;

endmodule

// File: tb/tb_hgcal_input_quant_packer.sv
// Directed bench for hgcal_input_quant_packer with NUM_INPUTS=4.
// Expected output words are queued when a complete frame is driven and are
// popped and compared whenever the DUT completes an output handshake.
module tb_hgcal_input_quant_packer;

  localparam int IW = 10;
  localparam int QB = 2;
  localparam int NI = 4;
  localparam int SH = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_data;
  logic          s_valid, s_last, s_ready;
  logic [NI*QB-1:0] m_data;
  logic          m_valid, m_ready, frame_err;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  logic [NI*QB-1:0] exp_q[$];

  hgcal_input_quant_packer #(
    .IN_WIDTH(IW), .QUANT_BITS(QB), .NUM_INPUTS(NI), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference quantizer.
  function automatic logic [QB-1:0] qm(input int d);
    int v;
`ifdef HGCAL_QUANT_ROUND_EN
    v = (d + 32) >> SH;
`else
    v = d >> SH;
`endif
    if (v > 3) v = 3;
    return v[QB-1:0];
  endfunction

  function automatic logic [NI*QB-1:0] word_of(input int d0, input int d1, input int d2, input int d3);
    logic [NI*QB-1:0] w;
    w[1:0] = qm(d0);
    w[3:2] = qm(d1);
    w[5:4] = qm(d2);
    w[7:6] = qm(d3);
    return w;
  endfunction

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic send(input int d, input logic l);
    logic acc;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = IW'(d);
    s_last  = l;
    forever begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int d0, input int d1, input int d2, input int d3);
    send(d0, 1'b0);
    send(d1, 1'b0);
    send(d2, 1'b0);
    send(d3, 1'b1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: scoreboard pop, hold-stability check, error pulse count.
  logic             prev_stall = 1'b0;
  logic [NI*QB-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (frame_err === 1'b1) err_cnt++;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
        else chk("word", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      end
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data  = m_data;
    end
  end

  initial begin
    int e0;
    int d[4];
    logic [NI*QB-1:0] wa, wb;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;

    // Reset values
    tick(3);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_m_valid", {31'd0, m_valid}, 32'd0);

    // Basic frame
    m_ready = 1'b1;
    exp_q.push_back(8'b11100100);
    send_frame(0, 64, 130, 1023);
    chk("basic_latency_valid", {31'd0, m_valid}, 32'd1);
    chk("basic_data", {24'd0, m_data}, 32'hE4);
    tick(2);
    chk("basic_valid_clear", {31'd0, m_valid}, 32'd0);

    // Back-pressure
    m_ready = 1'b0;
    wa = word_of(70, 200, 10, 600);
    wb = word_of(1000, 5, 128, 64);
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    send_frame(70, 200, 10, 600);
    send_frame(1000, 5, 128, 64);
    chk("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
    chk("bp_first_word", {24'd0, m_data}, {24'd0, wa});
    tick(3);
    chk("bp_still_held", {24'd0, m_data}, {24'd0, wa});
    chk("bp_s_ready_held", {31'd0, s_ready}, 32'd0);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("bp_second_word", {24'd0, m_data}, {24'd0, wb});
    chk("bp_second_valid", {31'd0, m_valid}, 32'd1);
    chk("bp_s_ready_back", {31'd0, s_ready}, 32'd1);
    tick(2);
    m_ready = 1'b1;
    tick(2);
    chk("bp_drained", {31'd0, m_valid}, 32'd0);

    // Short frame
    e0 = err_cnt;
    send(100, 1'b0);
    send(200, 1'b0);
    send(300, 1'b1);
    chk("short_err_pulse", {31'd0, frame_err}, 32'd1);
    chk("short_no_valid", {31'd0, m_valid}, 32'd0);
    tick(1);
    chk("short_err_clear", {31'd0, frame_err}, 32'd0);
    tick(2);
    chk("short_err_count", 32'(err_cnt - e0), 32'd1);
    exp_q.push_back(word_of(63, 127, 191, 255));
    send_frame(63, 127, 191, 255);
    tick(2);

    // Long frame
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send(640 + i, 1'b0);
    send(900, 1'b1);
    tick(3);
    chk("long_err_count", 32'(err_cnt - e0), 32'd1);
    chk("long_no_valid", {31'd0, m_valid}, 32'd0);
    exp_q.push_back(word_of(500, 20, 64, 129));
    send_frame(500, 20, 64, 129);
    tick(2);

    // Reset mid-frame
    e0 = err_cnt;
    send(1023, 1'b0);
    send(1023, 1'b0);
    rst = 1'b1;
    tick(2);
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    tick(1);
    chk("midrst_s_ready", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(word_of(200, 0, 90, 1000));
    send_frame(200, 0, 90, 1000);
    tick(2);
    chk("midrst_err_count", 32'(err_cnt - e0), 32'd0);

    // Rounding vs truncation boundary values
`ifdef HGCAL_QUANT_ROUND_EN
    exp_q.push_back(8'b11100101);
`else
    exp_q.push_back(8'b11010100);
`endif
    send_frame(32, 95, 96, 200);
    tick(2);

    // A few random frames back to back
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) d[i] = int'($urandom_range(0, 1023));
      exp_q.push_back(word_of(d[0], d[1], d[2], d[3]));
      send_frame(d[0], d[1], d[2], d[3]);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
